// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with per-register
// in-flight writer scoreboard for the dual-issue core's ID stage.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   resetn     - synchronous active-low reset (clears data, counts, sb_err)
//   raddr      - NUM_RD packed read addresses, port i at [i*AW +: AW]
//   rdata      - NUM_RD packed read data, combinational
//   rbusy      - per read port: addressed register has in-flight writers
//   we         - per write port, per byte write enables
//   waddr      - per write port address (also the commit target)
//   wdata      - per write port data
//   wcommit    - per write port: retire one in-flight writer of waddr
//   iss_valid  - ID issues an instruction writing iss_addr
//   iss_addr   - destination register of the issued instruction
//   iss_ready  - 0 when the writer count of iss_addr is saturated
//   sb_err     - sticky flag: a commit found a zero writer count
module regfile_mp_sb #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int NB = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR*NB-1:0]     we,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR-1:0]        wcommit,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ready,
  output logic                     sb_err
);

  logic [DATA_W-1:0] r_regs      [NUM_REGS];
  logic [CNT_W-1:0]  r_cnt       [NUM_REGS];
  logic              r_sb_err;

  logic [DATA_W-1:0] w_regs_next [NUM_REGS];
  logic [CNT_W-1:0]  w_cnt_next  [NUM_REGS];
  logic [NUM_REGS-1:0] w_under;
  logic [CNT_W-1:0]  w_iss_cnt;
  logic              w_iss_ready;

  // Post-edge register contents. Ports are applied in ascending order so the
  // highest-indexed port wins each byte independently. Register 0 is never
  // written, and addresses beyond NUM_REGS match no entry.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_regs_next[r] = r_regs[r];
      if (r != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (waddr[p*AW +: AW] == AW'(r)) begin
            for (int b = 0; b < NB; b++) begin
              if (we[p*NB + b]) begin
                w_regs_next[r][b*8 +: 8] = wdata[p*DATA_W + b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Count of the issue target; register 0 and out-of-range addresses stay
  // at zero so they always report ready.
  always_comb begin
    w_iss_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (iss_addr == AW'(r)) begin
        w_iss_cnt = r_cnt[r];
      end
    end
    w_iss_ready = (w_iss_cnt != {CNT_W{1'b1}});
  end

  assign iss_ready = w_iss_ready || !resetn;

  // Scoreboard update: +1 for an accepted issue, -1 per committing port.
  // Because an issue is only accepted below saturation, the sum never
  // overflows; a result below zero clamps to 0 and flags underflow.
  always_comb begin
    int v_up;
    int v_dn;
    int v_sum;
    v_up  = 0;
    v_dn  = 0;
    v_sum = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_next[r] = r_cnt[r];
      w_under[r]    = 1'b0;
      if (r != 0) begin
        v_up = (iss_valid && w_iss_ready && (iss_addr == AW'(r))) ? 1 : 0;
        v_dn = 0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (wcommit[p] && (waddr[p*AW +: AW] == AW'(r))) begin
            v_dn = v_dn + 1;
          end
        end
        v_sum = int'(r_cnt[r]) + v_up;
        if (v_sum < v_dn) begin
          w_cnt_next[r] = '0;
          w_under[r]    = 1'b1;
        end else begin
          w_cnt_next[r] = CNT_W'(v_sum - v_dn);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= w_regs_next[r];
        r_cnt[r]  <= w_cnt_next[r];
      end
      if (|w_under) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign sb_err = r_sb_err;

  // Read ports. With bypass the post-edge value is returned, which already
  // folds in same-cycle writes with correct byte priority. Busy always uses
  // the registered count and ignores same-cycle commits.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [DATA_W-1:0] w_rd;
    logic              w_busy;

    always_comb begin
      w_rd   = '0;
      w_busy = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (raddr[gi*AW +: AW] == AW'(r)) begin
          w_rd   = (BYPASS != 0) ? w_regs_next[r] : r_regs[r];
          w_busy = (r_cnt[r] != '0);
        end
      end
      if (!resetn) begin
        w_rd   = '0;
        w_busy = 1'b0;
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = w_rd;
    assign rbusy[gi]                  = w_busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: drives a bypassing and a non-bypassing instance with
// identical stimulus; directed vectors, scoreboard corner cases and a
// randomized phase checked against a simple array-based model.
module tb_regfile_mp_sb;

  logic         clk = 1'b0;
  logic         resetn;
  logic [19:0]  raddr;
  logic [127:0] rdata_b, rdata_n;
  logic [3:0]   rbusy_b, rbusy_n;
  logic [7:0]   we;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [1:0]   wcommit;
  logic         iss_valid;
  logic [4:0]   iss_addr;
  logic         iss_ready_b, iss_ready_n, sb_err_b, sb_err_n;

  always #5 clk = ~clk;

  regfile_mp_sb #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(4), .NUM_WR(2),
                  .CNT_W(2), .BYPASS(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_b),
    .rbusy(rbusy_b), .we(we), .waddr(waddr), .wdata(wdata),
    .wcommit(wcommit), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready_b), .sb_err(sb_err_b));

  regfile_mp_sb #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(4), .NUM_WR(2),
                  .CNT_W(2), .BYPASS(0)) u_dut_n (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata_n),
    .rbusy(rbusy_n), .we(we), .waddr(waddr), .wdata(wdata),
    .wcommit(wcommit), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready_n), .sb_err(sb_err_n));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  bit          m_err;

  // Value register a holds after the coming edge (given current inputs).
  function automatic logic [31:0] m_after(input int a);
    logic [31:0] v;
    v = m_mem[a];
    if (a == 0) return 32'h0;
    for (int p = 0; p < 2; p++)
      if (int'(waddr[p*5 +: 5]) == a)
        for (int b = 0; b < 4; b++)
          if (we[p*4 + b]) v[b*8 +: 8] = wdata[p*32 + b*8 +: 8];
    return v;
  endfunction

  function automatic bit m_ready();
    return (iss_addr == 5'd0) || (m_cnt[iss_addr] != 3);
  endfunction

  task automatic model_step();
    logic [31:0] nm [32];
    int up, dn, t;
    bit rdy;
    if (!resetn) begin
      for (int a = 0; a < 32; a++) begin
        m_mem[a] = 32'h0;
        m_cnt[a] = 0;
      end
      m_err = 1'b0;
      return;
    end
    rdy = m_ready();
    for (int a = 0; a < 32; a++) nm[a] = m_after(a);
    for (int a = 1; a < 32; a++) begin
      up = (iss_valid && rdy && int'(iss_addr) == a) ? 1 : 0;
      dn = 0;
      for (int p = 0; p < 2; p++)
        if (wcommit[p] && int'(waddr[p*5 +: 5]) == a) dn++;
      t = m_cnt[a] + up - dn;
      if (t < 0) begin
        t = 0;
        m_err = 1'b1;
      end
      m_cnt[a] = t;
    end
    for (int a = 0; a < 32; a++) m_mem[a] = nm[a];
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    raddr = '0; we = '0; waddr = '0; wdata = '0;
    wcommit = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic issue(input logic [4:0] a);
    idle();
    iss_valid = 1'b1;
    iss_addr  = a;
    tick();
  endtask

  task automatic commit1(input logic [4:0] a);
    idle();
    wcommit = 2'b01;
    waddr[4:0] = a;
    tick();
  endtask

  task automatic check_model(input int n);
    logic [4:0] a;
    for (int i = 0; i < 4; i++) begin
      a = raddr[i*5 +: 5];
      chk($sformatf("rnd%0d_rdata_byp_p%0d", n, i), rdata_b[i*32 +: 32],
          resetn ? m_after(int'(a)) : 32'h0);
      chk($sformatf("rnd%0d_rdata_nob_p%0d", n, i), rdata_n[i*32 +: 32],
          resetn ? m_mem[a] : 32'h0);
      chk($sformatf("rnd%0d_rbusy_p%0d", n, i), {31'b0, rbusy_b[i]},
          {31'b0, resetn && (m_cnt[a] != 0)});
      chk($sformatf("rnd%0d_rbusy_nob_p%0d", n, i), {31'b0, rbusy_n[i]},
          {31'b0, resetn && (m_cnt[a] != 0)});
    end
    chk($sformatf("rnd%0d_iss_ready", n), {31'b0, iss_ready_b}, {31'b0, !resetn || m_ready()});
    chk($sformatf("rnd%0d_sb_err", n), {31'b0, sb_err_b}, {31'b0, m_err});
    chk($sformatf("rnd%0d_sb_err_nob", n), {31'b0, sb_err_n}, {31'b0, m_err});
  endtask

  // ---------------- directed write vectors ----------------
  typedef struct {
    logic [4:0]  wa0, wa1;
    logic [3:0]  we0, we1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra;
    logic [31:0] exp_byp, exp_nb_now, exp_after;
  } vec_t;

  vec_t tab [6];

  initial begin
    tab[0] = '{5'd5,  5'd0,  4'hF,    4'h0,    32'h11223344, 32'h0,        5'd5,  32'h11223344, 32'h00000000, 32'h11223344};
    tab[1] = '{5'd5,  5'd0,  4'b0101, 4'h0,    32'hAABBCCDD, 32'h0,        5'd5,  32'h11BB33DD, 32'h11223344, 32'h11BB33DD};
    tab[2] = '{5'd0,  5'd0,  4'hF,    4'h0,    32'h11223344, 32'h0,        5'd0,  32'h00000000, 32'h00000000, 32'h00000000};
    tab[3] = '{5'd7,  5'd7,  4'hF,    4'b1100, 32'h00000001, 32'hFFFF0000, 5'd7,  32'hFFFF0001, 32'h00000000, 32'hFFFF0001};
    tab[4] = '{5'd12, 5'd12, 4'hF,    4'hF,    32'hDEADBEEF, 32'h01020304, 5'd12, 32'h01020304, 32'h00000000, 32'h01020304};
    tab[5] = '{5'd12, 5'd12, 4'b0011, 4'b1000, 32'h0000BEEF, 32'h77000000, 5'd12, 32'h7702BEEF, 32'h01020304, 32'h7702BEEF};

    // ---- reset, then every register on all 4 ports ----
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int base = 0; base < 32; base += 4) begin
      raddr = {5'(base + 3), 5'(base + 2), 5'(base + 1), 5'(base)};
      iss_addr = 5'(base);
      #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("reset_rdata_r%0d", base + i), rdata_b[i*32 +: 32], 32'h0);
        chk($sformatf("reset_rdata_nob_r%0d", base + i), rdata_n[i*32 +: 32], 32'h0);
        chk($sformatf("reset_rbusy_r%0d", base + i), {31'b0, rbusy_b[i]}, 32'h0);
      end
      chk($sformatf("reset_iss_ready_r%0d", base), {31'b0, iss_ready_b}, 32'h1);
      chk("reset_sb_err", {31'b0, sb_err_b}, 32'h0);
    end
    $display("reset read sweep done");

    // ---- table-driven write / bypass vectors ----
    for (int i = 0; i < 6; i++) begin
      idle();
      waddr = {tab[i].wa1, tab[i].wa0};
      we    = {tab[i].we1, tab[i].we0};
      wdata = {tab[i].wd1, tab[i].wd0};
      raddr[4:0] = tab[i].ra;
      #1;
      chk($sformatf("vec%0d_same_cycle_bypass", i), rdata_b[31:0], tab[i].exp_byp);
      chk($sformatf("vec%0d_same_cycle_nobypass", i), rdata_n[31:0], tab[i].exp_nb_now);
      tick();
      idle();
      raddr[4:0] = tab[i].ra;
      #1;
      chk($sformatf("vec%0d_next_cycle_nobypass", i), rdata_n[31:0], tab[i].exp_after);
      chk($sformatf("vec%0d_next_cycle_bypass", i), rdata_b[31:0], tab[i].exp_after);
      $display("vec %0d: r%0d byp=%h nob=%h", i, tab[i].ra, rdata_b[31:0], rdata_n[31:0]);
    end

    // ---- scoreboard saturation on r3 ----
    for (int k = 0; k < 3; k++) issue(5'd3);
    idle(); raddr[9:5] = 5'd3; iss_addr = 5'd3; #1;
    chk("sat_busy_after3", {31'b0, rbusy_b[1]}, 32'h1);
    chk("sat_ready_after3", {31'b0, iss_ready_b}, 32'h0);
    issue(5'd3);
    idle(); raddr[9:5] = 5'd3; iss_addr = 5'd3; #1;
    chk("sat_busy_after4", {31'b0, rbusy_b[1]}, 32'h1);
    chk("sat_ready_after4_no_wrap", {31'b0, iss_ready_b}, 32'h0);
    commit1(5'd3);
    commit1(5'd3);
    idle(); raddr[9:5] = 5'd3; #1;
    chk("sat_busy_after2commits", {31'b0, rbusy_b[1]}, 32'h1);
    commit1(5'd3);
    idle(); raddr[9:5] = 5'd3; iss_addr = 5'd3; #1;
    chk("sat_busy_after3commits", {31'b0, rbusy_b[1]}, 32'h0);
    chk("sat_ready_after3commits", {31'b0, iss_ready_b}, 32'h1);
    chk("sat_no_sb_err", {31'b0, sb_err_b}, 32'h0);
    issue(5'd3);
    idle(); iss_valid = 1'b1; iss_addr = 5'd3; wcommit = 2'b10; waddr[9:5] = 5'd3;
    tick();
    idle(); raddr[9:5] = 5'd3; #1;
    chk("iss_commit_same_cycle_busy", {31'b0, rbusy_b[1]}, 32'h1);
    commit1(5'd3);
    idle(); raddr[9:5] = 5'd3; #1;
    chk("iss_commit_then_drain_busy", {31'b0, rbusy_b[1]}, 32'h0);
    chk("iss_commit_no_sb_err", {31'b0, sb_err_b}, 32'h0);
    $display("scoreboard saturation sequence done");

    // ---- underflow ----
    commit1(5'd9);
    idle(); #1;
    chk("underflow_sets_sb_err", {31'b0, sb_err_b}, 32'h1);
    issue(5'd9);
    commit1(5'd9);
    idle(); raddr[4:0] = 5'd9; #1;
    chk("sb_err_sticky", {31'b0, sb_err_b}, 32'h1);
    chk("sb_err_sticky_busy", {31'b0, rbusy_b[0]}, 32'h0);
    resetn = 1'b0; tick(); resetn = 1'b1;
    idle(); #1;
    chk("sb_err_cleared_by_reset", {31'b0, sb_err_b}, 32'h0);
    issue(5'd9);
    idle(); wcommit = 2'b11; waddr = {5'd9, 5'd9};
    tick();
    idle(); raddr[4:0] = 5'd9; #1;
    chk("double_commit_busy", {31'b0, rbusy_b[0]}, 32'h0);
    chk("double_commit_sb_err", {31'b0, sb_err_b}, 32'h1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    idle(); #1;
    chk("sb_err_cleared_again", {31'b0, sb_err_b}, 32'h0);
    $display("underflow sequence done");

    // ---- reset in the middle of traffic ----
    idle(); we = 8'h0F; waddr[4:0] = 5'd4; wdata[31:0] = 32'h00001234;
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    issue(5'd4);
    for (int k = 0; k < 3; k++) issue(5'd6);
    idle(); raddr[4:0] = 5'd4; iss_addr = 5'd6; #1;
    chk("midrst_pre_data", rdata_n[31:0], 32'h00001234);
    chk("midrst_pre_busy", {31'b0, rbusy_b[0]}, 32'h1);
    chk("midrst_pre_r6_ready", {31'b0, iss_ready_b}, 32'h0);
    resetn = 1'b0;
    we = 8'h0F; waddr[4:0] = 5'd4; wdata[31:0] = 32'h00005678;
    iss_valid = 1'b1; iss_addr = 5'd6;
    #1;
    chk("during_reset_rdata_byp", rdata_b[31:0], 32'h0);
    chk("during_reset_rbusy", {31'b0, rbusy_b[0]}, 32'h0);
    chk("during_reset_iss_ready", {31'b0, iss_ready_b}, 32'h1);
    tick();
    resetn = 1'b1;
    idle(); raddr[4:0] = 5'd4; iss_addr = 5'd6; #1;
    chk("after_reset_r4_data", rdata_n[31:0], 32'h0);
    chk("after_reset_r4_data_byp", rdata_b[31:0], 32'h0);
    chk("after_reset_r4_busy", {31'b0, rbusy_n[0]}, 32'h0);
    chk("after_reset_r6_ready", {31'b0, iss_ready_n}, 32'h1);
    $display("mid-operation reset sequence done");

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      we = 8'($urandom);
      wdata = {$urandom, $urandom};
      for (int p = 0; p < 2; p++) begin
        waddr[p*5 +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 7));
        wcommit[p] = ($urandom_range(0, 3) == 0);
      end
      iss_valid = ($urandom_range(0, 9) < 7);
      iss_addr  = 5'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++)
        raddr[i*5 +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 7));
      #1;
      check_model(n);
      $display("rnd %0d: rst_n=%0b we=%h wa=%h wc=%b iss=%0b/%0d ra=%h rd0=%h",
               n, resetn, we, waddr, wcommit, iss_valid, iss_addr, raddr, rdata_b[31:0]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Next-generation integer register file for the dual-issue MIPS core, replacing the single-write, 2-read register file in ID.
- Parametrised read and write port counts, data width and register count; per-byte write enables on every write port.
- Optional write-to-read bypass.
- Integrated scoreboard tracking in-flight writers per register, so ID can stall on RAW hazards without a separate hazard table.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero
DATA_W, 32, register width; must be a multiple of 8
NUM_RD, 4, number of read ports
NUM_WR, 2, number of write (commit) ports; higher index has higher priority
CNT_W, 2, width of per-register in-flight writer counter
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  synchronous active-low reset
raddr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW], AW = $clog2(NUM_REGS)
rdata  out  NUM_RD*DATA_W  read data, combinational
rbusy  out  NUM_RD  1 = register at raddr[i] has in-flight writers
we  in  NUM_WR*(DATA_W/8)  per-byte write enables per write port
waddr  in  NUM_WR*AW  write addresses
wdata  in  NUM_WR*DATA_W  write data
wcommit  in  NUM_WR  1 = this write port retires one in-flight writer of waddr
iss_valid  in  1  ID issues an instruction writing iss_addr
iss_addr  in  AW  destination register of issued instruction
iss_ready  out  1  0 = counter for iss_addr saturated; issue must not proceed
sb_err  out  1  sticky: a commit hit a register with count 0

Behaviour:
- Reset (resetn=0 at posedge): all registers cleared to 0, all counters cleared to 0, sb_err cleared. Reset overrides any write/issue/commit in the same cycle. Reset asserted mid-operation discards all pending state.
- During reset: rdata=0, rbusy=0, iss_ready=1.
- Write: at posedge, for each byte b of register waddr[p], the byte takes wdata[p] byte b if we[p][b]. Bytes with no enable hold.
- Same address and same byte on several ports in one cycle: highest-indexed port wins, per byte independently.
- Register 0: writes ignored, reads return 0, never busy, issues and commits to it ignored (no counter change, no sb_err).
- Read: rdata[i] = stored value of raddr[i], latency 0.
  - If BYPASS=1: each byte is replaced by the highest-priority same-cycle enabled write byte to that address, i.e. identical to the value the register holds after the edge.
- Scoreboard:
  - Per register, count[r] (CNT_W bits).
  - Next-state delta = +1 if (iss_valid && iss_ready && iss_addr==r), minus the number of ports p with wcommit[p] && waddr[p]==r.
  - Decrements saturate at 0. Any commit that would drive a count below 0 sets sb_err; sb_err stays 1 until reset.
  - Simultaneous issue and one commit to the same register: count unchanged.
  - wcommit is independent of we: a commit with we=0 (e.g. a cancelled load) retires the writer without changing data.
- rbusy[i] = (count[raddr[i]] != 0), combinational from registered counts; it does not look ahead to same-cycle commits, even when BYPASS=1.
- iss_ready = (count[iss_addr] != 2^CNT_W-1) || iss_addr==0.
  - iss_valid with iss_ready=0 is ignored; the count does not wrap.
- No X propagation: unread or out-of-range addresses (NUM_REGS not a power of 2) read 0 and are never busy; writes, issues and commits to them are ignored.

Test Plan:
- Reset then read all regs on 4 ports -> rdata=0, rbusy=0, iss_ready=1, sb_err=0.
- Byte-enable write:
  - write r5=0x11223344 we=4'hF;
  - next cycle write r5 wdata=0xAABBCCDD we=4'b0101;
  - read r5 -> 0x11BB33DD. Same write to r0 -> r0 reads 0.
- Port conflict and bypass:
  - port0 writes r7=0x00000001 we=F, port1 writes r7=0xFFFF0000 we=4'b1100, same cycle;
  - same-cycle read with BYPASS=1 -> 0xFFFF0001;
  - next-cycle read with BYPASS=0 -> 0xFFFF0001, same-cycle read with BYPASS=0 -> old value.
- Scoreboard saturation with CNT_W=2:
  - issue r3 three times -> rbusy for r3=1, iss_ready=0;
  - fourth issue -> count stays 3;
  - 3 commits -> rbusy=0;
  - issue+commit r3 in same cycle at count 1 -> count stays 1.
- Underflow: commit r9 at count 0 -> sb_err=1 and stays 1 after further valid traffic. Two ports committing r9 at count 1 -> count 0, sb_err=1. Reset -> sb_err=0.
- Reset mid-operation: r4 count=2 and r4=0x1234; assert resetn=0 in the same cycle as a write r4=0x5678 -> after the edge r4=0, rbusy=0.
